// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register downstream of the ALU.
// Holds a multicycle instruction in EX while its result is pending and injects
// NOP bubbles into MEM meanwhile. A finished result is parked in a one-deep skid
// buffer across a MEM stall. The stage also drives the EX->ID forwarding path,
// and a watchdog limits how long a single BUSY period can last.
// Optional feature macro: EX_MEM_PERF_EN enables the bubble and retire
// performance counters. When it is undefined, both perf outputs are tied to 0.
module ex_mem_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_STALL  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_res,
  input  logic                  ex_insert_bubble,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [2:0]            ex_funct3,
  input  logic                  flush,
  input  logic                  mem_stall,
  output logic                  stall_upstream,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_alu_res,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [DATA_W-1:0]     mem_store_data,
  output logic [2:0]            mem_funct3,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  stall_timeout,
  output logic [31:0]           perf_bubble_cnt,
  output logic [31:0]           perf_retire_cnt
);

  localparam int unsigned CNT_W = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STALL - 1);

  typedef struct packed {
    logic [DATA_W-1:0]     alu_res;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     store_data;
    logic [2:0]            funct3;
  } payload_t;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t     state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  payload_t   ex_payload, skid_q, skid_nxt, mem_q, load_data;
  logic       mem_valid_q, fwd_valid_q, stall_timeout_q;
  logic       load, load_valid, timeout_fire;

  // Pack the EX-side fields into one payload
  always_comb begin
    ex_payload            = '0;
    ex_payload.alu_res    = ex_alu_res;
    ex_payload.rd         = ex_rd;
    ex_payload.reg_write  = ex_reg_write;
    ex_payload.mem_read   = ex_mem_read;
    ex_payload.mem_write  = ex_mem_write;
    ex_payload.store_data = ex_store_data;
    ex_payload.funct3     = ex_funct3;
  end

  // Next-state, skid and MEM-load decisions; flush outranks mem_stall outranks normal flow
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    skid_nxt     = skid_q;
    load         = 1'b0;
    load_valid   = 1'b0;
    load_data    = ex_payload;
    timeout_fire = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      count_nxt = '0;
      skid_nxt  = '0;
      load      = !mem_stall;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_valid && ex_insert_bubble) begin
            state_nxt = BUSY;
            count_nxt = '0;
          end
          load       = !mem_stall;
          load_valid = ex_valid && !ex_insert_bubble;
        end
        BUSY: begin
          if (!ex_valid) begin
            state_nxt = IDLE;
            count_nxt = '0;
            load      = !mem_stall;
          end else if (ex_insert_bubble) begin
            if (count == CNT_LAST) begin
              timeout_fire = 1'b1;
              state_nxt    = IDLE;
              count_nxt    = '0;
            end else begin
              count_nxt = count + CNT_W'(1);
            end
            load = !mem_stall;
          end else begin
            count_nxt = '0;
            if (mem_stall) begin
              skid_nxt  = ex_payload;
              state_nxt = HOLD;
            end else begin
              load       = 1'b1;
              load_valid = 1'b1;
              state_nxt  = IDLE;
            end
          end
        end
        HOLD: begin
          if (!mem_stall) begin
            load       = 1'b1;
            load_valid = 1'b1;
            load_data  = skid_q;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Freeze the front of the pipe while EX waits, the skid is occupied or MEM stalls
  always_comb begin
    stall_upstream = (ex_valid && ex_insert_bubble && !timeout_fire) ||
                     (state == HOLD) || mem_stall;
  end

  // State, watchdog, skid and MEM-slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      skid_q          <= '0;
      mem_q           <= '0;
      mem_valid_q     <= 1'b0;
      fwd_valid_q     <= 1'b0;
      stall_timeout_q <= 1'b0;
    end else begin
      state           <= state_nxt;
      count           <= count_nxt;
      skid_q          <= skid_nxt;
      stall_timeout_q <= stall_timeout_q || timeout_fire;
      if (load) begin
        mem_valid_q <= load_valid;
        mem_q       <= load_valid ? load_data : '0;
        fwd_valid_q <= load_valid && load_data.reg_write && !load_data.mem_read &&
                       (load_data.rd != '0);
      end
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_alu_res    = mem_q.alu_res;
  assign mem_rd         = mem_q.rd;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_store_data = mem_q.store_data;
  assign mem_funct3     = mem_q.funct3;
  assign fwd_valid      = fwd_valid_q;
  assign fwd_rd         = mem_q.rd;
  assign fwd_data       = mem_q.alu_res;
  assign stall_timeout  = stall_timeout_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] bubble_cnt_q, retire_cnt_q;

  // Wrap-around counts of injected bubbles and retired instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (load && !load_valid && ex_valid) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (load && load_valid)              retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_retire_cnt = retire_cnt_q;
`else
  assign perf_bubble_cnt = 32'd0;
  assign perf_retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed scenarios plus randomized traffic for ex_mem_stage,
// run on two instances (watchdog limit 64 and 8) checked against a behavioural model.
`timescale 1ns/1ps
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic [2:0]  f3;
  } pl_t;

  logic clk = 1'b0;
  logic rst, ex_valid, ex_insert_bubble, ex_reg_write, ex_mem_read, ex_mem_write, flush, mem_stall;
  logic [31:0] ex_alu_res, ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;

  logic [1:0]  su, mv, mrw, mmr, mmw, fv, sto;
  logic [31:0] mres [2];
  logic [31:0] msd  [2];
  logic [31:0] fdat [2];
  logic [31:0] pbub [2];
  logic [31:0] pret [2];
  logic [4:0]  mrd  [2];
  logic [4:0]  frd  [2];
  logic [2:0]  mf3  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .MAX_STALL(g == 0 ? 64 : 8)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
      .ex_insert_bubble(ex_insert_bubble), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
      .ex_funct3(ex_funct3), .flush(flush), .mem_stall(mem_stall),
      .stall_upstream(su[g]), .mem_valid(mv[g]), .mem_alu_res(mres[g]), .mem_rd(mrd[g]),
      .mem_reg_write(mrw[g]), .mem_mem_read(mmr[g]), .mem_mem_write(mmw[g]),
      .mem_store_data(msd[g]), .mem_funct3(mf3[g]), .fwd_valid(fv[g]), .fwd_rd(frd[g]),
      .fwd_data(fdat[g]), .stall_timeout(sto[g]),
      .perf_bubble_cnt(pbub[g]), .perf_retire_cnt(pret[g])
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model: one record per instance
  bit          busy [2];
  int          run [2];
  bit          have_skid [2];
  pl_t         skid_pl [2];
  bit          e_v [2];
  pl_t         e_pl [2];
  bit          e_fwd [2];
  bit          e_to [2];
  logic [31:0] e_bub [2];
  logic [31:0] e_ret [2];

  // Observation tallies used by the directed scenarios
  int          su_seen0, valid_seen0, valid_seen1;
  logic [31:0] last_res0;
  logic [1:0]  last_su;

  function automatic int max_stall(int k);
    return (k == 0) ? 64 : 8;
  endfunction

  function automatic pl_t cur_pl();
    pl_t p;
    p.res = ex_alu_res; p.rd = ex_rd; p.rw = ex_reg_write; p.mr = ex_mem_read;
    p.mw = ex_mem_write; p.sd = ex_store_data; p.f3 = ex_funct3;
    return p;
  endfunction

  function automatic bit fire_now(int k);
    return !flush && !have_skid[k] && busy[k] && ex_valid && ex_insert_bubble &&
           (run[k] == max_stall(k) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s @cycle %0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit ld, lv, f;
    pl_t lp;
    ld = 0; lv = 0; lp = cur_pl(); f = fire_now(k);
    if (rst) begin
      busy[k] = 0; run[k] = 0; have_skid[k] = 0; e_v[k] = 0; e_pl[k] = '0;
      e_fwd[k] = 0; e_to[k] = 0; e_bub[k] = 0; e_ret[k] = 0;
      return;
    end
    if (flush) begin
      busy[k] = 0; run[k] = 0; have_skid[k] = 0; ld = !mem_stall;
    end else if (have_skid[k]) begin
      if (!mem_stall) begin ld = 1; lv = 1; lp = skid_pl[k]; have_skid[k] = 0; end
    end else if (busy[k]) begin
      if (!ex_valid) begin
        busy[k] = 0; run[k] = 0; ld = !mem_stall;
      end else if (ex_insert_bubble) begin
        if (f) begin busy[k] = 0; run[k] = 0; end
        else run[k]++;
        ld = !mem_stall;
      end else begin
        busy[k] = 0; run[k] = 0;
        if (mem_stall) begin have_skid[k] = 1; skid_pl[k] = lp; end
        else begin ld = 1; lv = 1; end
      end
    end else begin
      if (ex_valid && ex_insert_bubble) begin busy[k] = 1; run[k] = 0; end
      ld = !mem_stall; lv = ex_valid && !ex_insert_bubble;
    end
    if (f) e_to[k] = 1;
    if (ld) begin
      e_v[k]   = lv;
      e_pl[k]  = lv ? lp : '0;
      e_fwd[k] = lv && lp.rw && !lp.mr && (lp.rd != 0);
      if (!lv && ex_valid) e_bub[k] = e_bub[k] + 32'd1;
      if (lv)              e_ret[k] = e_ret[k] + 32'd1;
    end
  endtask

  task automatic check_out(input int k);
    string s;
    s = (k == 0) ? "i0" : "i1";
    chk({"mem_valid_", s}, 32'(mv[k]), 32'(e_v[k]));
    chk({"fwd_valid_", s}, 32'(fv[k]), 32'(e_fwd[k]));
    chk({"stall_timeout_", s}, 32'(sto[k]), 32'(e_to[k]));
    if (e_v[k]) begin
      chk({"mem_alu_res_", s}, mres[k], e_pl[k].res);
      chk({"mem_rd_", s}, 32'(mrd[k]), 32'(e_pl[k].rd));
      chk({"mem_ctl_", s}, 32'({mrw[k], mmr[k], mmw[k], mf3[k]}),
          32'({e_pl[k].rw, e_pl[k].mr, e_pl[k].mw, e_pl[k].f3}));
      chk({"mem_store_data_", s}, msd[k], e_pl[k].sd);
      chk({"fwd_rd_", s}, 32'(frd[k]), 32'(e_pl[k].rd));
      chk({"fwd_data_", s}, fdat[k], e_pl[k].res);
    end
`ifdef EX_MEM_PERF_EN
    chk({"perf_bubble_", s}, pbub[k], e_bub[k]);
    chk({"perf_retire_", s}, pret[k], e_ret[k]);
`else
    chk({"perf_bubble_", s}, pbub[k], 32'd0);
    chk({"perf_retire_", s}, pret[k], 32'd0);
`endif
  endtask

  // One clock: check comb stall, advance model, check registered outputs after the edge
  task automatic cycle();
    #1;
    last_su = su;
    for (int k = 0; k < 2; k++) begin
      if (!rst)
        chk((k == 0) ? "stall_upstream_i0" : "stall_upstream_i1", 32'(su[k]),
            32'((ex_valid && ex_insert_bubble && !fire_now(k)) || have_skid[k] || mem_stall));
      model_step(k);
    end
    if (su[0]) su_seen0++;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) check_out(k);
    if (mv[0]) begin valid_seen0++; last_res0 = mres[0]; end
    if (mv[1]) valid_seen1++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; ex_valid = 0; ex_insert_bubble = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_mem_write = 0; flush = 0; mem_stall = 0; ex_alu_res = 0; ex_store_data = 0;
    ex_rd = 0; ex_funct3 = 0;
  endtask

  task automatic clear_tallies();
    su_seen0 = 0; valid_seen0 = 0; valid_seen1 = 0; last_res0 = 0;
  endtask

  initial begin
    int first_to;
    idle_inputs();
    rst = 1;
    cycle(); cycle();
    chk("reset_mem_valid", 32'(mv), 32'd0);
    chk("reset_stall_timeout", 32'(sto), 32'd0);
    chk("reset_fwd_valid", 32'(fv), 32'd0);
    rst = 0;
    cycle();

    // Single-cycle ADD, visible one edge later with forwarding
    ex_valid = 1; ex_alu_res = 32'h5; ex_rd = 5'd3; ex_reg_write = 1;
    cycle();
    chk("t1_mem_valid", 32'(mv[0]), 32'd1);
    chk("t1_res", mres[0], 32'h5);
    chk("t1_fwd_valid", 32'(fv[0]), 32'd1);
    chk("t1_fwd_rd", 32'(frd[0]), 32'd3);
    idle_inputs(); cycle();

    // 32-cycle divide: 32 stalled cycles then exactly one result
    clear_tallies();
    ex_valid = 1; ex_insert_bubble = 1; ex_rd = 5'd9; ex_reg_write = 1;
    repeat (32) cycle();
    ex_insert_bubble = 0; ex_alu_res = 32'h7;
    cycle();
    idle_inputs(); cycle();
    chk("t2_stall_cycles", 32'(su_seen0), 32'd32);
    chk("t2_valid_count", 32'(valid_seen0), 32'd1);
    chk("t2_res", last_res0, 32'h7);

    // Completion under MEM stall parks the result until release
    clear_tallies();
    ex_valid = 1; ex_insert_bubble = 1; ex_rd = 5'd6; ex_reg_write = 1;
    cycle();
    ex_insert_bubble = 0; ex_alu_res = 32'h1234; mem_stall = 1;
    cycle();
    ex_valid = 0;
    cycle();
    chk("t3_hold_stall", 32'(last_su[0]), 32'd1);
    cycle();
    chk("t3_no_early_valid", 32'(valid_seen0), 32'd0);
    mem_stall = 0;
    cycle();
    chk("t3_release_valid", 32'(mv[0]), 32'd1);
    chk("t3_release_res", mres[0], 32'h1234);
    idle_inputs(); cycle(); cycle();
    chk("t3_once", 32'(valid_seen0), 32'd1);

    // Flush on the fifth BUSY cycle squashes the instruction
    clear_tallies();
    ex_valid = 1; ex_insert_bubble = 1; ex_rd = 5'd2; ex_reg_write = 1;
    repeat (5) cycle();
    flush = 1;
    cycle();
    idle_inputs();
    cycle();
    chk("t4_stall_after_flush", 32'(last_su[0]), 32'd0);
    chk("t4_no_valid", 32'(valid_seen0 + valid_seen1), 32'd0);

    // Watchdog: instance with limit 8 fires on its eighth BUSY cycle
    rst = 1; cycle(); rst = 0;
    ex_valid = 1; ex_insert_bubble = 1;
    first_to = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 9) chk("t5_fire_stall", 32'(last_su[1]), 32'd0);
      if (sto[1] && first_to == 0) first_to = i;
    end
    chk("t5_first_timeout_cycle", 32'(first_to), 32'd9);
    chk("t5_sticky", 32'(sto[1]), 32'd1);
    chk("t5_no_timeout_i0", 32'(sto[0]), 32'd0);
    idle_inputs(); cycle();

    // Forwarding suppressed for x0 and loads; retire count from reset
    rst = 1; cycle(); rst = 0;
    ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd0; ex_alu_res = 32'hAA;
    cycle();
    chk("t6_fwd_x0", 32'(fv[0]), 32'd0);
    ex_rd = 5'd4; ex_mem_read = 1; ex_alu_res = 32'h100;
    cycle();
    chk("t6_fwd_load", 32'(fv[0]), 32'd0);
    idle_inputs(); cycle();
`ifdef EX_MEM_PERF_EN
    chk("t6_retire", pret[0], 32'd2);
`else
    chk("t6_retire", pret[0], 32'd0);
`endif

    // Randomized traffic; second half biases toward long multicycle waits
    for (int i = 0; i < 1600; i++) begin
      rst              = ($urandom_range(0, 299) == 0);
      ex_valid         = ($urandom_range(0, 3) != 0);
      ex_insert_bubble = (i < 800) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) != 0);
      flush            = ($urandom_range(0, 19) == 0);
      mem_stall        = ($urandom_range(0, 3) == 0);
      ex_alu_res       = $urandom;
      ex_store_data    = $urandom;
      ex_rd            = 5'($urandom_range(0, 31));
      ex_reg_write     = 1'($urandom_range(0, 1));
      ex_mem_read      = ($urandom_range(0, 3) == 0);
      ex_mem_write     = ($urandom_range(0, 3) == 0);
      ex_funct3        = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
